// File: rtl/mdu_pkg.sv
// rtl/mdu_pkg.sv - shared op/state encodings for the RV32M multiply/divide unit
package mdu_pkg;

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } mdu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BUSY,
    ST_DONE
  } mdu_state_e;

  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

endpackage

// File: rtl/mdu_datapath.sv
// rtl/mdu_datapath.sv - operand magnitudes, shift-add / restoring-divide iteration and sign fixup
// MDU_EARLY_OUT_EN: raises early for zero-operand multiplies and divide-by-zero / overflow divides.
module mdu_datapath
  import mdu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            load,
  input  logic            step,
  input  logic            finish,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            early,
  output logic [XLEN-1:0] result
);

  localparam logic [XLEN-1:0] ONES    = '1;
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  mdu_op_e           op_in, op_q;
  logic              a_neg_in, b_neg_in, dbz_in, ovf_in;
  logic [XLEN-1:0]   a_mag_in, b_mag_in, early_res;
  logic [XLEN-1:0]   b_mag, a_raw;
  logic [2*XLEN-1:0] p, p_nxt, prod_fix;
  logic [XLEN:0]     pr, pr_nxt, sum;
  logic [XLEN+1:0]   shifted, diff;
  logic              ge, neg_q, neg_r, dbz, ovf;
  logic [XLEN-1:0]   quo, rmd, final_res;

  always_comb begin
    op_in    = mdu_op_e'(funct3);
    a_neg_in = op_a[XLEN-1] && (op_in inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM});
    b_neg_in = op_b[XLEN-1] && (op_in inside {OP_MULH, OP_DIV, OP_REM});
    a_mag_in = a_neg_in ? -op_a : op_a;
    b_mag_in = b_neg_in ? -op_b : op_b;
    dbz_in   = funct3[2] && (op_b == '0);
    ovf_in   = (op_in inside {OP_DIV, OP_REM}) && (op_a == MIN_NEG) && (op_b == ONES);
    case (op_in)
      OP_DIV, OP_DIVU: early_res = dbz_in ? ONES : MIN_NEG;
      OP_REM, OP_REMU: early_res = dbz_in ? op_a : '0;
      default:         early_res = '0;
    endcase
  end

`ifdef MDU_EARLY_OUT_EN
  assign early = funct3[2] ? (dbz_in || ovf_in) : ((op_a == '0) || (op_b == '0));
`else
  assign early = 1'b0;
`endif

  // p holds {accumulator, multiplier} for multiply and {unused, quotient/dividend} for divide
  always_comb begin
    sum     = {1'b0, p[2*XLEN-1:XLEN]} + (p[0] ? {1'b0, b_mag} : '0);
    shifted = {pr, p[XLEN-1]};
    diff    = shifted - {2'b00, b_mag};
    ge      = !diff[XLEN+1];
    if (op_q[2]) begin
      p_nxt  = {p[2*XLEN-1:XLEN], p[XLEN-2:0], ge};
      pr_nxt = ge ? diff[XLEN:0] : shifted[XLEN:0];
    end else begin
      p_nxt  = {sum, p[XLEN-1:1]};
      pr_nxt = pr;
    end
    prod_fix = neg_q ? -p_nxt : p_nxt;
    quo      = neg_q ? -p_nxt[XLEN-1:0] : p_nxt[XLEN-1:0];
    rmd      = neg_r ? -pr_nxt[XLEN-1:0] : pr_nxt[XLEN-1:0];
    case (op_q)
      OP_MUL:                       final_res = prod_fix[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: final_res = prod_fix[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:              final_res = dbz ? ONES : (ovf ? MIN_NEG : quo);
      default:                      final_res = dbz ? a_raw : (ovf ? '0 : rmd);
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_q   <= OP_MUL;
      b_mag  <= '0;
      a_raw  <= '0;
      p      <= '0;
      pr     <= '0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      dbz    <= 1'b0;
      ovf    <= 1'b0;
      result <= '0;
    end else begin
      if (load) begin
        op_q  <= op_in;
        b_mag <= b_mag_in;
        a_raw <= op_a;
        p     <= {{XLEN{1'b0}}, a_mag_in};
        pr    <= '0;
        neg_q <= a_neg_in ^ b_neg_in;
        neg_r <= a_neg_in;
        dbz   <= dbz_in;
        ovf   <= ovf_in;
      end else if (step) begin
        p  <= p_nxt;
        pr <= pr_nxt;
      end
      // the final iteration and the result load share a cycle, so fixup reads the next-state values
      if (finish) result <= load ? early_res : final_res;
    end
  end

endmodule

// File: rtl/mdu_sequencer.sv
// rtl/mdu_sequencer.sv - IDLE/BUSY/DONE sequencer for the iterative RV32M multiply/divide unit
// MDU_EARLY_OUT_EN: special/zero-operand ops go IDLE->DONE directly (flag decoded in mdu_datapath).
module mdu_sequencer
  import mdu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic            flush,
  output logic            stall,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int CW = $clog2(XLEN);

  mdu_state_e    state;
  logic [CW-1:0] counter;
  logic          load, step, last, finish, early;

  assign load   = (state == ST_IDLE) && start && !flush;
  assign step   = (state == ST_BUSY) && !flush;
  assign last   = (counter == CW'(XLEN-1));
  assign finish = (step && last) || (load && early);
  assign stall  = load || (state == ST_BUSY);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= ST_IDLE;
      counter <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (load) begin
            counter <= '0;
            if (early) begin
              state <= ST_DONE;
              done  <= 1'b1;
            end else begin
              state <= ST_BUSY;
              busy  <= 1'b1;
            end
          end
        end
        ST_BUSY: begin
          if (flush) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end else if (last) begin
            state <= ST_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            counter <= counter + CW'(1);
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
          done  <= 1'b0;
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

  mdu_datapath #(.XLEN(XLEN)) u_datapath (
    .clk    (clk),
    .reset  (reset),
    .load   (load),
    .step   (step),
    .finish (finish),
    .funct3 (funct3),
    .op_a   (op_a),
    .op_b   (op_b),
    .early  (early),
    .result (result)
  );

endmodule

// File: tb/tb_mdu_sequencer.sv
// tb/tb_mdu_sequencer.sv - self-checking bench for mdu_sequencer against an arithmetic reference model
module tb_mdu_sequencer;

  localparam int XLEN = 32;

  logic        clk = 1'b0;
  logic        reset, start, flush;
  logic [2:0]  funct3;
  logic [31:0] op_a, op_b;
  logic        stall, busy, done;
  logic [31:0] result;

  int checks = 0;
  int errors = 0;

`ifdef MDU_EARLY_OUT_EN
  bit early_en = 1'b1;
`else
  bit early_en = 1'b0;
`endif

  always #5 clk = ~clk;

  mdu_sequencer #(.XLEN(XLEN)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .funct3 (funct3),
    .op_a   (op_a),
    .op_b   (op_b),
    .flush  (flush),
    .stall  (stall),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  function automatic logic [31:0] model_result(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] sa, sb, za, zb, prod;
    int signed ia, ib;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    za = {32'b0, a};
    zb = {32'b0, b};
    ia = a;
    ib = b;
    case (f)
      3'd0: begin prod = za * zb; return prod[31:0]; end
      3'd1: begin prod = sa * sb; return prod[63:32]; end
      3'd2: begin prod = sa * zb; return prod[63:32]; end
      3'd3: begin prod = za * zb; return prod[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFFFFFF;
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h80000000;
        return ia / ib;
      end
      3'd5: return (b == 0) ? 32'hFFFFFFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h0;
        return ia % ib;
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int model_latency(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    bit special;
    if (f[2]) special = (b == 0) || (f == 3'd4 || f == 3'd6) && a == 32'h80000000 && b == 32'hFFFFFFFF;
    else      special = (a == 0) || (b == 0);
    return (early_en && special) ? 1 : XLEN + 1;
  endfunction

  // runs one operation; reports observed latency, result, stall/busy anomalies and done one cycle later
  task automatic do_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                       output int lat, output logic [31:0] res, output int stall_err, output logic done_after);
    @(posedge clk); #1;
    funct3 = f; op_a = a; op_b = b; start = 1'b1; flush = 1'b0;
    stall_err = 0;
    #1;
    if (stall !== 1'b1) stall_err++;
    lat = 100;
    for (int cyc = 1; cyc <= 100; cyc++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (done === 1'b1) begin
        lat = cyc;
        break;
      end
      if (stall !== 1'b1 || busy !== 1'b1) stall_err++;
    end
    if (stall !== 1'b0) stall_err++;
    res = result;
    @(posedge clk); #1;
    done_after = done;
  endtask

  task automatic test_reset();
    #1;
    checks++; if (busy !== 1'b0)    begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (done !== 1'b0)    begin errors++; $display("FAIL reset_done got %b want 0", done); end
    checks++; if (result !== 32'h0) begin errors++; $display("FAIL reset_result got %h want 0", result); end
    checks++; if (stall !== 1'b0)   begin errors++; $display("FAIL reset_stall got %b want 0", stall); end
  endtask

  task automatic test_directed();
    logic [2:0]  tf [14] = '{3'd0, 3'd1, 3'd3, 3'd2, 3'd4, 3'd6, 3'd5, 3'd7, 3'd5, 3'd7, 3'd4, 3'd6, 3'd0, 3'd6};
    logic [31:0] ta [14] = '{32'd7, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFF9, 32'hFFFFFFF9,
                             32'd100, 32'd100, 32'd5, 32'd5, 32'h80000000, 32'h80000000, 32'd0, 32'hFFFFFFF9};
    logic [31:0] tb [14] = '{32'hFFFFFFFD, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd2, 32'd2,
                             32'd7, 32'd7, 32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd1234, 32'd0};
    logic [31:0] te [14] = '{32'hFFFFFFEB, 32'h40000000, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'hFFFFFFFD, 32'hFFFFFFFF,
                             32'd14, 32'd2, 32'hFFFFFFFF, 32'd5, 32'h80000000, 32'd0, 32'd0, 32'hFFFFFFF9};
    int lat, serr;
    logic [31:0] res;
    logic dafter;
    for (int i = 0; i < 14; i++) begin
      do_op(tf[i], ta[i], tb[i], lat, res, serr, dafter);
      checks++; if (res !== te[i]) begin errors++; $display("FAIL dir%0d_result got %h want %h", i, res, te[i]); end
      checks++; if (lat != model_latency(tf[i], ta[i], tb[i])) begin
        errors++; $display("FAIL dir%0d_latency got %0d want %0d", i, lat, model_latency(tf[i], ta[i], tb[i])); end
      checks++; if (serr != 0) begin errors++; $display("FAIL dir%0d_stall got %0d bad cycles want 0", i, serr); end
      checks++; if (dafter !== 1'b0) begin errors++; $display("FAIL dir%0d_done_pulse got %b want 0", i, dafter); end
    end
  endtask

  task automatic test_random();
    int lat, serr, r;
    logic [31:0] a, b, res;
    logic [2:0] f;
    logic dafter;
    for (int i = 0; i < 40; i++) begin
      f = 3'($urandom_range(0, 7));
      r = $urandom_range(0, 7);
      a = (r == 0) ? 32'h0 : (r == 1) ? 32'h80000000 : $urandom;
      r = $urandom_range(0, 7);
      b = (r == 0) ? 32'h0 : (r == 1) ? 32'hFFFFFFFF : (r == 2) ? 32'($urandom_range(1, 9)) : $urandom;
      do_op(f, a, b, lat, res, serr, dafter);
      checks++; if (res !== model_result(f, a, b)) begin
        errors++; $display("FAIL rnd%0d_result op=%0d a=%h b=%h got %h want %h", i, f, a, b, res, model_result(f, a, b)); end
      checks++; if (lat != model_latency(f, a, b)) begin
        errors++; $display("FAIL rnd%0d_latency got %0d want %0d", i, lat, model_latency(f, a, b)); end
      checks++; if (serr != 0 || dafter !== 1'b0) begin
        errors++; $display("FAIL rnd%0d_handshake got stall_err=%0d done_after=%b want 0/0", i, serr, dafter); end
    end
  endtask

  task automatic test_flush();
    int lat, serr;
    logic [31:0] res, prev;
    logic dafter, seen;
    do_op(3'd4, 32'hFFFFFFF9, 32'd2, lat, prev, serr, dafter);
    @(posedge clk); #1;
    funct3 = 3'd4; op_a = 32'd1000; op_b = 32'd3; start = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      @(posedge clk); #1;
      start = 1'b0;
    end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL flush_pre_busy got %b want 1", busy); end
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    checks++; if (busy !== 1'b0)  begin errors++; $display("FAIL flush_busy got %b want 0", busy); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL flush_stall got %b want 0", stall); end
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (done === 1'b1) seen = 1'b1;
    end
    checks++; if (seen !== 1'b0)   begin errors++; $display("FAIL flush_no_done got %b want 0", seen); end
    checks++; if (result !== prev) begin errors++; $display("FAIL flush_result_held got %h want %h", result, prev); end
    do_op(3'd0, 32'd3, 32'd4, lat, res, serr, dafter);
    checks++; if (res !== 32'd12) begin errors++; $display("FAIL flush_next_mul got %h want 0000000c", res); end
    checks++; if (lat != XLEN + 1) begin errors++; $display("FAIL flush_next_latency got %0d want %0d", lat, XLEN + 1); end
  endtask

  task automatic test_start_held();
    int lat;
    @(posedge clk); #1;
    funct3 = 3'd0; op_a = 32'd5; op_b = 32'd6; start = 1'b1;
    lat = 100;
    for (int cyc = 1; cyc <= 100; cyc++) begin
      @(posedge clk); #1;
      if (done === 1'b1) begin lat = cyc; break; end
    end
    checks++; if (lat != XLEN + 1) begin errors++; $display("FAIL held_latency got %0d want %0d", lat, XLEN + 1); end
    checks++; if (result !== 32'd30) begin errors++; $display("FAIL held_result got %h want 0000001e", result); end
    @(posedge clk); #1;
    checks++; if (done !== 1'b0 || stall !== 1'b1) begin
      errors++; $display("FAIL held_reaccept got done=%b stall=%b want 0/1", done, stall); end
    lat = 100;
    for (int cyc = 1; cyc <= 100; cyc++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (done === 1'b1) begin lat = cyc; break; end
    end
    checks++; if (lat != XLEN + 1) begin errors++; $display("FAIL held_second_latency got %0d want %0d", lat, XLEN + 1); end
  endtask

  task automatic test_reset_mid();
    int lat, serr;
    logic [31:0] res;
    logic dafter;
    @(posedge clk); #1;
    funct3 = 3'd5; op_a = 32'd1000; op_b = 32'd7; start = 1'b1;
    for (int i = 1; i <= 15; i++) begin
      @(posedge clk); #1;
      start = 1'b0;
    end
    #2 reset = 1'b1;
    #1;
    checks++; if (busy !== 1'b0)    begin errors++; $display("FAIL rstmid_busy got %b want 0", busy); end
    checks++; if (done !== 1'b0)    begin errors++; $display("FAIL rstmid_done got %b want 0", done); end
    checks++; if (result !== 32'h0) begin errors++; $display("FAIL rstmid_result got %h want 0", result); end
    @(negedge clk);
    reset = 1'b0;
    do_op(3'd5, 32'd100, 32'd7, lat, res, serr, dafter);
    checks++; if (res !== 32'd14) begin errors++; $display("FAIL rstmid_next got %h want 0000000e", res); end
    checks++; if (lat != XLEN + 1) begin errors++; $display("FAIL rstmid_latency got %0d want %0d", lat, XLEN + 1); end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; flush = 1'b0; funct3 = 3'd0; op_a = '0; op_b = '0;
    repeat (2) @(posedge clk);
    test_reset();
    @(negedge clk);
    reset = 1'b0;
    test_directed();
    test_random();
    test_flush();
    test_start_held();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
